// File: rtl/ax_pwm_capture.sv
// PWM capture: synchronizes an asynchronous PWM input and measures the period and high time of each
// complete cycle in clk cycles. A stalled input is reported with a timeout pulse.
module ax_pwm_capture #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pwm_in,
  output logic [N-1:0] period_out,
  output logic [N-1:0] high_out,
  output logic         valid,
  output logic         timeout,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [N-1:0] CNT_ONE = N'(1);
  localparam logic [N-1:0] CNT_MAX = '1;

  state_t       state;
  logic         s1;
  logic         s2;
  logic         s3;
  logic [N-1:0] period_cnt;
  logic [N-1:0] high_cnt;
  logic         rise_c;
  logic         fall_c;

  assign rise_c = s2 & ~s3;
  assign fall_c = ~s2 & s3;

  // Synchronizer, measurement FSM and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      s1      <= pwm_in;
      s2      <= s1;
      s3      <= s2;
      valid   <= 1'b0;
      timeout <= 1'b0;

      case (state)
        IDLE: begin
          period_cnt <= '0;
          high_cnt   <= '0;
          if (rise_c) begin
            state      <= HIGH;
            busy       <= 1'b1;
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
          end
        end

        HIGH: begin
          if (fall_c) begin
            state      <= LOW;
            period_cnt <= period_cnt + CNT_ONE;
          end else if (period_cnt == CNT_MAX) begin
            state      <= IDLE;
            busy       <= 1'b0;
            timeout    <= 1'b1;
            period_cnt <= '0;
            high_cnt   <= '0;
          end else begin
            period_cnt <= period_cnt + CNT_ONE;
            high_cnt   <= high_cnt + CNT_ONE;
          end
        end

        LOW: begin
          // A rise closes this cycle and opens the next one with no gap
          if (rise_c) begin
            state      <= HIGH;
            period_out <= period_cnt;
            high_out   <= high_cnt;
            valid      <= 1'b1;
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
          end else if (period_cnt == CNT_MAX) begin
            state      <= IDLE;
            busy       <= 1'b0;
            timeout    <= 1'b1;
            period_cnt <= '0;
            high_cnt   <= '0;
          end else begin
            period_cnt <= period_cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
